adcemu_tx: RTL and testbench

ADC link emulator, the transmit-side counterpart of the ADC receiver. It produces, at the divided data clock, the parallel 6-bit-per-lane words that feed the OSERDES stage:
- 8 data lanes (4 channels × 2 lanes, 12-bit DDR, two-lane, bytewise, x1 frame);
- the frame lane;
- the trigger lane.

It is used on the bench and in loopback builds to exercise receiver alignment, bitslip and checking logic without a physical ADC. It adds selectable test patterns, a post-reset training phase, per-lane slip injection and trigger-time encoding.

---
 rtl/adcemu_tx.sv | 183 ++++++++++++++++++
 tb/tb_adcemu_tx.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/adcemu_tx.sv
// ADC link emulator, transmit side: pattern/training generation, trigger-time
// encoding and per-lane slip injection ahead of the OSERDES stage.

module adcemu_slip (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [2:0] i_s,
   input  logic [5:0] i_word,
   output logic [5:0] o_word
);
   logic [5:0]  r_prev;
   logic [5:0]  r_out;
   logic [11:0] w_cat;
   logic [2:0]  w_s;

   assign w_cat  = {r_prev, i_word};
   assign w_s    = (i_s > 3'd5) ? 3'd5 : i_s;
   assign o_word = r_out;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_prev <= '0;
         r_out  <= '0;
      end else begin
         r_prev <= i_word;
         r_out  <= w_cat[w_s +: 6];
      end
   end
endmodule

module adcemu_tx #(
   parameter int SYNC_LEN = 64,
   parameter int TRIG_LEN = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [47:0] DIN,
   input  logic        enb,
   input  logic [3:0]  chk_type,
   input  logic [26:0] slip,
   input  logic        sertrig,
   input  logic [2:0]  trtime,
   output logic [47:0] DOUT,
   output logic [5:0]  FROUT,
   output logic [5:0]  TROUT,
   output logic        ready
);
   localparam int          NUM_LANES = 10;
   localparam int          TCW       = $clog2(TRIG_LEN + 2);
   localparam logic [5:0]  SYNC_WORD = 6'b111000;

   typedef enum logic {ST_SYNC, ST_RUN} state_t;

   state_t      r_state, w_state_nxt;
   logic [11:0] r_sync_cnt, w_sync_cnt_nxt;
   logic [11:0] r_ramp;
   logic        r_phase;
   logic [47:0] r_pat, w_pat;
   logic [11:0] w_ch;
   logic [5:0]  r_fr;
   logic        r_ready;
   logic [5:0]  r_tr_word;
   logic [TCW-1:0] r_tr_cnt;
   logic [2:0]  w_t;
   logic [5:0]  w_lead;

   logic [NUM_LANES-1:0][5:0] w_lane_in;
   logic [NUM_LANES-1:0][5:0] w_lane_out;
   logic [NUM_LANES-1:0][2:0] w_lane_s;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state    <= ST_SYNC;
         r_sync_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_sync_cnt <= w_sync_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_sync_cnt_nxt = r_sync_cnt;
      case (r_state)
         ST_SYNC: begin
            if (r_sync_cnt == 12'(SYNC_LEN - 1)) begin
               w_state_nxt    = ST_RUN;
               w_sync_cnt_nxt = '0;
            end else begin
               w_sync_cnt_nxt = r_sync_cnt + 12'd1;
            end
         end
         default: w_state_nxt = ST_RUN;
      endcase
   end

   // Channel i occupies DIN/DOUT bits 12i+11:12i, so lanes 2i/2i+1 fall out directly.
   always_comb begin
      w_pat = '0;
      w_ch  = '0;
      if (r_state == ST_SYNC) begin
         w_pat = {8{SYNC_WORD}};
      end else begin
         for (int i = 0; i < 4; i++) begin
            case (chk_type)
               4'd0:    w_ch = DIN[12*i +: 12];
               4'd2:    w_ch = 12'hFFF;
               4'd3:    w_ch = r_phase ? 12'h555 : 12'hAAA;
               4'd4:    w_ch = r_ramp + 12'(i * 1024);
               default: w_ch = 12'h000;
            endcase
            if (!enb) w_ch = 12'h000;
            w_pat[12*i +: 12] = w_ch;
         end
      end
   end

   assign w_t    = (trtime > 3'd5) ? 3'd5 : trtime;
   assign w_lead = 6'h3F << w_t;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_pat     <= '0;
         r_fr      <= '0;
         r_ready   <= 1'b0;
         r_ramp    <= '0;
         r_phase   <= 1'b0;
         r_tr_word <= '0;
         r_tr_cnt  <= '0;
      end else begin
         r_pat   <= w_pat;
         r_fr    <= SYNC_WORD;
         r_ready <= (r_state == ST_RUN);
         // Ramp and phase free-run through enb=0 so data resumes in step.
         if (r_state == ST_RUN) begin
            r_ramp  <= r_ramp + 12'd1;
            r_phase <= ~r_phase;
         end else begin
            r_ramp  <= '0;
            r_phase <= 1'b0;
         end
         if (r_tr_cnt != '0) begin
            r_tr_word <= 6'h3F;
            r_tr_cnt  <= r_tr_cnt - 1'b1;
         end else if (sertrig) begin
            r_tr_word <= w_lead;
            r_tr_cnt  <= TCW'(TRIG_LEN);
         end else begin
            r_tr_word <= 6'h00;
         end
      end
   end

   generate
      for (genvar k = 0; k < 8; k++) begin : g_dmap
         assign w_lane_in[k] = r_pat[6*k +: 6];
         assign w_lane_s[k]  = slip[3*k +: 3];
      end
   endgenerate

   // Frame and trigger share one slip so the trigger stays coherent with frame.
   assign w_lane_in[8] = r_fr;
   assign w_lane_in[9] = r_tr_word;
   assign w_lane_s[8]  = slip[26:24];
   assign w_lane_s[9]  = slip[26:24];

   generate
      for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
         adcemu_slip u_slip (
            .i_clk  (CLK),
            .i_rst  (RST),
            .i_s    (w_lane_s[k]),
            .i_word (w_lane_in[k]),
            .o_word (w_lane_out[k])
         );
      end
   endgenerate

   assign DOUT  = w_lane_out[7:0];
   assign FROUT = w_lane_out[8];
   assign TROUT = w_lane_out[9];
   assign ready = r_ready;
endmodule

// File: tb/tb_adcemu_tx.sv
// Randomized bench for adcemu_tx against a per-cycle behavioural model of the
// pattern, training, trigger and slip rules.

module tb_adcemu_tx;
   localparam int SYNC_LEN = 64;
   localparam int TRIG_LEN = 4;

   logic        CLK = 1'b0;
   logic        RST, enb, sertrig, ready;
   logic [47:0] DIN, DOUT;
   logic [3:0]  chk_type;
   logic [26:0] slip;
   logic [2:0]  trtime;
   logic [5:0]  FROUT, TROUT;

   adcemu_tx #(.SYNC_LEN(SYNC_LEN), .TRIG_LEN(TRIG_LEN)) dut (
      .CLK(CLK), .RST(RST), .DIN(DIN), .enb(enb), .chk_type(chk_type),
      .slip(slip), .sertrig(sertrig), .trtime(trtime),
      .DOUT(DOUT), .FROUT(FROUT), .TROUT(TROUT), .ready(ready)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   // Stimulus applied on the next tick
   logic        s_rst = 1'b1, s_en = 1'b1, s_st = 1'b0;
   logic [3:0]  s_ck = 4'd0;
   logic [47:0] s_din = 48'h0;
   logic [26:0] s_slip = 27'h0;
   logic [2:0]  s_tt = 3'd0;

   // Model: n = edges since the reset edge, pre1/pre2 = last two pre-slip words
   int n = 0;
   int busy_end = 0;
   int pre1[10];
   int pre2[10];
   int nw[10];
   int e[10];
   logic [47:0] e_dout;
   logic [5:0]  e_fr, e_tr;
   logic        e_ready;

   task automatic model_edge();
      int v, r, s, t;
      if (s_rst) begin
         n = 0; busy_end = 0;
         for (int k = 0; k < 10; k++) begin pre1[k] = 0; pre2[k] = 0; e[k] = 0; end
         e_ready = 1'b0;
      end else begin
         n++;
         for (int c = 0; c < 4; c++) begin
            if (n <= SYNC_LEN) v = 12'hE38;
            else begin
               r = n - SYNC_LEN - 1;
               case (s_ck)
                  4'd0: v = int'(s_din[12*c +: 12]);
                  4'd2: v = 4095;
                  4'd3: v = (r % 2 == 1) ? 12'h555 : 12'hAAA;
                  4'd4: v = (r + 1024 * c) % 4096;
                  default: v = 0;
               endcase
               if (!s_en) v = 0;
            end
            nw[2*c]   = v % 64;
            nw[2*c+1] = v / 64;
         end
         nw[8] = 56;
         if (s_st && n >= busy_end) begin
            t = (s_tt > 5) ? 5 : int'(s_tt);
            nw[9] = (63 << t) % 64;
            busy_end = n + TRIG_LEN + 1;
         end else if (n < busy_end) nw[9] = 63;
         else nw[9] = 0;
         for (int k = 0; k < 10; k++) begin
            s = (k < 8) ? int'(s_slip[3*k +: 3]) : int'(s_slip[26:24]);
            if (s > 5) s = 5;
            e[k] = ((pre2[k] * 64 + pre1[k]) >> s) % 64;
            pre2[k] = pre1[k];
            pre1[k] = nw[k];
         end
         e_ready = (n >= SYNC_LEN + 1);
      end
      for (int k = 0; k < 8; k++) e_dout[6*k +: 6] = 6'(e[k]);
      e_fr = 6'(e[8]);
      e_tr = 6'(e[9]);
   endtask

   task automatic tick();
      RST = s_rst; enb = s_en; chk_type = s_ck; DIN = s_din;
      slip = s_slip; sertrig = s_st; trtime = s_tt;
      model_edge();
      @(posedge CLK);
      #1;
      checks++;
      assert (DOUT === e_dout) else begin
         errors++; $error("FAIL dout n=%0d obs=%h exp=%h", n, DOUT, e_dout);
      end
      checks++;
      assert (FROUT === e_fr) else begin
         errors++; $error("FAIL frout n=%0d obs=%b exp=%b", n, FROUT, e_fr);
      end
      checks++;
      assert (TROUT === e_tr) else begin
         errors++; $error("FAIL trout n=%0d obs=%b exp=%b", n, TROUT, e_tr);
      end
      checks++;
      assert (ready === e_ready) else begin
         errors++; $error("FAIL ready n=%0d obs=%b exp=%b", n, ready, e_ready);
      end
   endtask

   initial begin
      // Reset
      s_rst = 1'b1; tick(); tick();
      checks++;
      assert (DOUT === 48'h0 && ready === 1'b0) else begin
         errors++; $error("FAIL reset_state obs=%h/%b exp=0/0", DOUT, ready);
      end
      s_rst = 1'b0;

      // Training then DIN passthrough
      s_ck = 4'd0; s_din = 48'h123456789ABC; s_slip = '0;
      for (int i = 0; i < SYNC_LEN + 8; i++) tick();
      checks++;
      assert (DOUT === 48'h123456789ABC && ready === 1'b1) else begin
         errors++; $error("FAIL passthru obs=%h exp=123456789abc", DOUT);
      end

      // Ramp across a wrap, with a 3-cycle enb gap
      s_ck = 4'd4;
      for (int i = 0; i < 4200; i++) begin
         s_din = {$urandom, $urandom};
         s_en  = !(i >= 100 && i < 103);
         tick();
      end
      s_en = 1'b1;

      // Alternating pattern
      s_ck = 4'd3;
      for (int i = 0; i < 20; i++) tick();

      // Slip on lane 0: all-ones then all-zeros, with slip 2, 7 and 5
      s_slip = 27'd2;
      s_ck = 4'd2; for (int i = 0; i < 5; i++) tick();
      s_ck = 4'd1; for (int i = 0; i < 5; i++) tick();
      s_slip = 27'd7;
      s_ck = 4'd2; for (int i = 0; i < 5; i++) tick();
      s_ck = 4'd1; for (int i = 0; i < 3; i++) tick();
      checks++;
      assert (DOUT[5:0] === 6'b000000) else begin
         errors++; $error("FAIL slip7_zero obs=%b exp=000000", DOUT[5:0]);
      end
      s_slip = 27'd5;
      s_ck = 4'd2; for (int i = 0; i < 5; i++) tick();
      s_ck = 4'd1; for (int i = 0; i < 3; i++) tick();
      s_slip = '0;

      // Trigger: trtime=3, a second request during hold, then trtime=6
      s_ck = 4'd0;
      s_st = 1'b1; s_tt = 3'd3; tick();
      s_st = 1'b0; tick();
      checks++;
      assert (TROUT === 6'b111000) else begin
         errors++; $error("FAIL trig_lead obs=%b exp=111000", TROUT);
      end
      for (int i = 0; i < TRIG_LEN; i++) begin
         s_st = (i == 1); tick();
         checks++;
         assert (TROUT === 6'h3F) else begin
            errors++; $error("FAIL trig_hold i=%0d obs=%b exp=111111", i, TROUT);
         end
      end
      s_st = 1'b0; tick();
      checks++;
      assert (TROUT === 6'h00) else begin
         errors++; $error("FAIL trig_end obs=%b exp=000000", TROUT);
      end
      s_st = 1'b1; s_tt = 3'd6; tick();
      s_st = 1'b0; tick();
      checks++;
      assert (TROUT === 6'b100000) else begin
         errors++; $error("FAIL trig_t6 obs=%b exp=100000", TROUT);
      end
      for (int i = 0; i < 6; i++) tick();

      // Random mix of everything
      for (int i = 0; i < 2000; i++) begin
         s_ck   = 4'($urandom_range(0, 15));
         s_din  = {$urandom, $urandom};
         s_slip = 27'($urandom);
         s_en   = ($urandom_range(0, 9) != 0);
         s_st   = ($urandom_range(0, 7) == 0);
         s_tt   = 3'($urandom);
         tick();
      end

      // Reset mid-RUN, then a full training phase again
      s_rst = 1'b1; s_st = 1'b0; s_slip = '0; s_en = 1'b1; s_ck = 4'd0; tick();
      checks++;
      assert (DOUT === 48'h0 && FROUT === 6'h0 && TROUT === 6'h0 && ready === 1'b0) else begin
         errors++; $error("FAIL midrun_reset obs=%h/%b exp=0/0", DOUT, ready);
      end
      s_rst = 1'b0;
      for (int i = 0; i < SYNC_LEN + 6; i++) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
